// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, PC-select codes
// and the decoded-flag bundle captured in DECODE.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_ALU = 2'b10;

    typedef struct packed {
        logic lw;
        logic sw;
        logic jump;
        logic jalr;
        logic branch;
        logic no_wb;
    } dec_flags_t;

    // JALR wins over everything; JAL and taken branches use PC+imm.
    function automatic logic [1:0] pc_sel_of(input dec_flags_t f, input logic taken);
        if (f.jalr) begin
            return PC_ALU;
        end else if (f.jump || (f.branch && taken)) begin
            return PC_IMM;
        end
        return PC_INC;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_watchdog.sv
// Wait-state counter shared by FETCH and MEM. Counts cycles spent waiting for
// a memory ready; flags a timeout when the count has reached the limit and the
// memory is still not ready.
module multicycle_sequencer_mem_wait_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign timeout = inc && (cnt_q == LIMIT);

    // Next count: clear on state change, else advance while waiting (never past the limit).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with run/halt
// control, a memory wait watchdog and a retired-instruction counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_lw,
    input  logic             dec_sw,
    input  logic             dec_jump,
    input  logic             dec_jalr,
    input  logic             dec_branch,
    input  logic             dec_no_wb,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    dec_flags_t       flags_q, flags_d;
    logic             taken_q, taken_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic wd_inc;
    logic wd_clr;
    logic wd_timeout;

    // Waiting means sitting in a memory state with no ready this cycle.
    assign wd_inc = ((state_q == ST_FETCH) && !imem_ready) ||
                    ((state_q == ST_MEM)   && !dmem_ready);
    assign wd_clr = (state_d != state_q);

    multicycle_sequencer_mem_wait_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .timeout (wd_timeout)
    );

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERR);
    assign halted  = (state_q == ST_HALT);
    assign err     = (state_q == ST_ERR);
    assign state_o = state_q;
    assign instret = instret_q;

    // Next-state, flag capture and strobe generation.
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        taken_d     = taken_q;
        halt_pend_d = halt_pend_q | halt_req;
        instret_d   = instret_q;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_INC;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wd_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                flags_d = '{lw: dec_lw, sw: dec_sw, jump: dec_jump,
                            jalr: dec_jalr, branch: dec_branch, no_wb: dec_no_wb};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                taken_d = br_taken;
                state_d = (flags_q.lw || flags_q.sw) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = flags_q.sw;
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else if (wd_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                pc_we     = 1'b1;
                rf_we     = !flags_q.no_wb && !flags_q.sw;
                pc_sel    = pc_sel_of(flags_q, taken_q);
                instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (halt_pend_q || halt_req) begin
                    state_d     = ST_HALT;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (run) state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Reset takes effect on the coming edge; keep the reset cycle strobe-free.
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = PC_INC;
        end
    end

    // State and latched-context registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flags_q     <= '0;
            taken_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            taken_q     <= taken_d;
            halt_pend_q <= halt_pend_d;
            instret_q   <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the driver pushes the expected
// write-back and memory-access results per instruction; a monitor pops and
// compares them whenever the DUT strobes pc_we or completes a data access.
module tb_multicycle_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n, run, halt_req, imem_ready, dmem_ready;
    logic        dec_lw, dec_sw, dec_jump, dec_jalr, dec_branch, dec_no_wb, br_taken;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
    logic [1:0]  pc_sel;
    logic        busy, halted, err;
    logic [2:0]  state_o;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dec_lw(dec_lw), .dec_sw(dec_sw), .dec_jump(dec_jump), .dec_jalr(dec_jalr),
        .dec_branch(dec_branch), .dec_no_wb(dec_no_wb), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy), .halted(halted),
        .err(err), .state_o(state_o), .instret(instret)
    );

    typedef struct {
        bit          rf_we;
        bit [1:0]    pc_sel;
        int          lat;
        int unsigned instret_before;
    } exp_t;

    exp_t        wb_q[$];
    bit          mem_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned model_instret = 0;

    // Instruction kinds
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_JAL = 3, K_JALR = 4, K_BR = 5, K_NOWB = 6;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        run = 0; halt_req = 0; imem_ready = 0; dmem_ready = 0;
        dec_lw = 0; dec_sw = 0; dec_jump = 0; dec_jalr = 0; dec_branch = 0; dec_no_wb = 0;
        br_taken = 0;
    endtask

    // Random values on inputs the current state must ignore.
    task automatic garbage();
        run = 1'($urandom); halt_req = 0;
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        dec_lw = 1'($urandom); dec_sw = 1'($urandom); dec_jump = 1'($urandom);
        dec_jalr = 1'($urandom); dec_branch = 1'($urandom); dec_no_wb = 1'($urandom);
        br_taken = 1'($urandom);
    endtask

    // One full instruction: iw/dw = wait cycles before imem/dmem ready.
    task automatic do_instr(input int kind, input bit taken, input int iw, input int dw, input bit hreq);
        bit   lw, sw, jmp, jr, br, nowb, is_mem;
        exp_t e;
        lw = (kind == K_LW); sw = (kind == K_SW); jmp = (kind == K_JAL);
        jr = (kind == K_JALR); br = (kind == K_BR);
        nowb = sw || br || (kind == K_NOWB);
        is_mem = lw || sw;
        e.rf_we  = !nowb && !sw;
        e.pc_sel = jr ? 2'b10 : ((jmp || (br && taken)) ? 2'b01 : 2'b00);
        e.lat    = (iw + 1) + 1 + 1 + (is_mem ? dw + 1 : 0) + 1;
        e.instret_before = model_instret;
        model_instret++;
        wb_q.push_back(e);
        if (is_mem) mem_q.push_back(sw);
        $display("instr kind=%0d taken=%0d iw=%0d dw=%0d halt=%0d exp_rf_we=%0d exp_pc_sel=%0d exp_lat=%0d",
                 kind, taken, iw, dw, hreq, e.rf_we, e.pc_sel, e.lat);

        for (int c = 0; c <= iw; c++) begin
            garbage();
            imem_ready = (c == iw);
            #1;
            chk("state_fetch", state_o, 1);
            chk("imem_req", imem_req, 1);
            chk("ir_we", ir_we, (c == iw) ? 1 : 0);
            step();
        end
        garbage();
        dec_lw = lw; dec_sw = sw; dec_jump = jmp; dec_jalr = jr; dec_branch = br; dec_no_wb = nowb;
        halt_req = hreq;
        #1;
        chk("state_decode", state_o, 2);
        step();
        garbage();
        br_taken = taken;
        #1;
        chk("state_exec", state_o, 3);
        step();
        if (is_mem) begin
            for (int c = 0; c <= dw; c++) begin
                garbage();
                dmem_ready = (c == dw);
                #1;
                chk("state_mem", state_o, 4);
                chk("dmem_req", dmem_req, 1);
                step();
            end
        end
        garbage();
        #1;
        chk("state_wb", state_o, 5);
        step();
        quiet();
    endtask

    task automatic halt_then_resume();
        quiet();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("state_halt", state_o, 6);
            chk("halted", halted, 1);
            chk("busy_halt", busy, 0);
            chk("instret_halt", instret, model_instret);
            step();
        end
        run = 1;
        step();
        run = 0;
    endtask

    // Monitor: pop and compare on every DUT write-back and data access.
    initial begin
        int busy_cyc;
        exp_t e;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy_cyc = 0;
            end else begin
                if (busy) busy_cyc++;
                if (dmem_req && dmem_ready) begin
                    if (mem_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL dmem_access actual=unexpected required=none");
                    end else begin
                        chk("dmem_we", dmem_we, mem_q.pop_front());
                    end
                end
                if (pc_we) begin
                    if (wb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL pc_we actual=unexpected required=none");
                    end else begin
                        e = wb_q.pop_front();
                        chk("rf_we", rf_we, e.rf_we);
                        chk("pc_sel", pc_sel, e.pc_sel);
                        chk("latency", busy_cyc, e.lat);
                        chk("instret_at_wb", instret, e.instret_before);
                    end
                    busy_cyc = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        rst_n = 0;
        step(); step(); step();
        chk("rst_state", state_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_we", pc_we, 0);
        rst_n = 1;
        step();
        chk("idle_hold", state_o, 0);
        run = 1;
        step();
        run = 0;

        // Directed mix from the plan
        do_instr(K_ALU,  0, 0, 0, 0);
        do_instr(K_LW,   0, 0, 3, 0);
        do_instr(K_SW,   0, 0, 0, 0);
        do_instr(K_BR,   1, 0, 0, 0);
        do_instr(K_BR,   0, 0, 0, 0);
        do_instr(K_JALR, 0, 1, 0, 0);
        do_instr(K_JAL,  0, 0, 0, 0);
        do_instr(K_LW,   0, TO, TO, 0);
        do_instr(K_ALU,  0, 0, 0, 1);
        halt_then_resume();

        // Randomized stream
        for (int n = 0; n < 40; n++) begin
            bit h;
            h = ($urandom_range(7) == 0);
            do_instr($urandom_range(6), 1'($urandom), $urandom_range(TO), $urandom_range(TO), h);
            if (h) halt_then_resume();
        end

        // Fetch watchdog: no imem_ready
        for (int c = 0; c <= TO; c++) begin
            garbage();
            imem_ready = 0;
            #1;
            chk("state_fetch_wait", state_o, 1);
            step();
        end
        quiet();
        #1;
        chk("err_state", state_o, 7);
        chk("err_flag", err, 1);
        chk("err_busy", busy, 0);
        chk("err_imem_req", imem_req, 0);
        run = 1;
        step();
        run = 0;
        chk("err_run_ignored", state_o, 7);
        chk("err_sticky", err, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        model_instret = 0;
        chk("err_rst_state", state_o, 0);
        chk("err_rst_err", err, 0);
        chk("err_rst_instret", instret, 0);

        // Reset while a load sits in MEM
        run = 1;
        step();
        quiet();
        imem_ready = 1;
        step();
        quiet();
        dec_lw = 1;
        step();
        quiet();
        step();
        #1;
        chk("mem_pre_rst_state", state_o, 4);
        chk("mem_pre_rst_req", dmem_req, 1);
        rst_n = 0;
        #1;
        chk("mem_rst_cycle_pc_we", pc_we, 0);
        chk("mem_rst_cycle_rf_we", rf_we, 0);
        step();
        chk("mem_rst_state", state_o, 0);
        chk("mem_rst_dmem_req", dmem_req, 0);
        chk("mem_rst_instret", instret, 0);
        rst_n = 1;
        step();
        chk("mem_rst_idle", state_o, 0);

        run = 1;
        step();
        run = 0;
        do_instr(K_ALU, 0, 0, 0, 0);
        chk("instret_after_rst", instret, 1);

        step(); step();
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the RV32 subset datapath used by the merge-sort core: fetch, decode, execute, memory, write-back.
- Consumes the decoded control flags from the instruction decoder plus memory ready handshakes.
- Drives the enable strobes for IR, PC, register-file write and data memory.
- Adds run/halt control, a memory wait-state watchdog and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 255: max wait cycles for imem_ready/dmem_ready before ERR (1..255).
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  start/resume pulse, honoured in IDLE and HALT
- halt_req  in  1  request stop at next instruction boundary
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- dec_lw  in  1  decoded load
- dec_sw  in  1  decoded store
- dec_jump  in  1  decoded JAL
- dec_jalr  in  1  decoded JALR
- dec_branch  in  1  decoded conditional branch
- dec_no_wb  in  1  instruction writes no register (1 = inhibit)
- br_taken  in  1  ALU compare result, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR)
- busy  out  1  FSM not in IDLE/HALT/ERR
- halted  out  1  FSM in HALT
- err  out  1  watchdog fired; sticky until reset
- state_o  out  3  current state encoding
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. All outputs 0, instret=0, wait counter=0, halt_pend=0, latched flags=0.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - imem_req=1 held every cycle in FETCH.
  - imem_ready=1 -> ir_we=1 for that cycle, -> DECODE.
  - Else wait counter increments; counter==MEM_TIMEOUT with no ready -> ERR.
- DECODE: one cycle. dec_* latched at end of cycle. -> EXEC.
- EXEC: one cycle. br_taken latched. -> MEM if latched lw|sw, else -> WB.
- MEM:
  - dmem_req=1, dmem_we=latched sw, both held until dmem_ready.
  - dmem_ready -> WB. Same watchdog rule as FETCH -> ERR.
- WB: one cycle.
  - pc_we=1. rf_we = ~no_wb & ~sw.
  - pc_sel = 10 if jalr; 01 if jump, or branch&taken; else 00.
  - instret += 1, wrapping at 2^CNT_W.
  - halt_pend|halt_req -> HALT, else -> FETCH.
- HALT: halted=1; halt_pend cleared on entry; run=1 -> FETCH.
- ERR: err=1. Terminal; only rst_n exits. All strobes 0.
- Wait counter clears on every state change.
- halt_req in any state sets halt_pend. Taken only at WB, so an instruction is never aborted.
- run while busy: ignored.
- Strobes (ir_we, rf_we, pc_we) are single-cycle and combinational from state plus latched flags.
- Reset mid-instruction: immediate return to IDLE; no strobe asserted in the reset cycle.
- Latency, zero-wait memory: 4 cycles per ALU/branch/jump instruction, 5 per load/store.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.

Decomposition:
- Shared package holds:
  - state enum/localparams (3-bit encoding above)
  - pc_sel codes PC_INC=2'b00, PC_IMM=2'b01, PC_ALU=2'b10
- One sub-module: mem_wait_watchdog. Counter, clear, inc, MEM_TIMEOUT compare, timeout output. Instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset then run pulse, ADDI flags, imem_ready immediate -> states 1,2,3,5,1; rf_we=1 and pc_we=1 in cycle 4, pc_sel=00, instret=1.
- Load with dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we=1 at WB, total 8 cycles.
- Store, then branch with br_taken=1, then branch with br_taken=0:
  - store: dmem_we=1, rf_we=0
  - taken branch: pc_sel=01
  - untaken branch: pc_sel=00
  - JALR: pc_sel=10
- halt_req pulsed during DECODE -> instruction completes WB, state=6, halted=1; run pulse -> FETCH, instret unchanged until next WB.
- imem_ready held 0 with MEM_TIMEOUT=4 -> ERR after 4 wait cycles, err=1, run ignored; rst_n=0 -> IDLE, err=0.
- rst_n=0 asserted during MEM -> next cycle state=0, dmem_req=0, instret=0, no rf_we/pc_we pulse.
